// File: rtl/i2c_master.sv
// Single-master I2C initiator: START, 7-bit address + R/W, len data bytes with ACK/NACK, STOP.
// Define I2C_MASTER_STRETCH_EN to let a slave stretch SCL while it is released.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | lines released, waiting for start
// START    | bus idle for half a bit, then sda low while scl high
// ADDR     | shifting {address,rw} out MSB first
// ADDR_ACK | sda released, slave ACK sampled
// WR       | shifting a write byte out MSB first
// WR_ACK   | sda released, slave ACK sampled, sended pulses on ACK
// RD       | sda released, 8 bits shifted in MSB first
// RD_ACK   | master drives ACK while bytes remain, NACK on the last
// STOP     | sda low with scl low, scl released, then sda released
module i2c_master #(
   parameter logic [7:0] QDIV = 8'd50
) (
   input  logic       clk,
   input  logic       reset,
   inout  wire        sda,
   inout  wire        scl,
   input  logic       start,
   input  logic [6:0] address,
   input  logic       rw,
   input  logic [3:0] len,
   input  logic [7:0] datasend,
   output logic       sended,
   output logic [7:0] datareceive,
   output logic       received,
   output logic       busy,
   output logic       nack
);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_STOP
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] qcnt_q, qcnt_d;
   logic [1:0] phase_q, phase_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bitcnt_q, bitcnt_d;
   logic [3:0] rem_q, rem_d;
   logic       rw_q, rw_d;
   logic       busy_q, busy_d;
   logic       nack_q, nack_d;
   logic       sended_q, sended_d;
   logic       received_q, received_d;
   logic [7:0] drx_q, drx_d;
   logic       sda_s1_q, sda_s2_q;
   logic       hold, tick, bit_end, sample;
   logic       sda_low, scl_low;

`ifdef I2C_MASTER_STRETCH_EN
   logic scl_s1_q, scl_s2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         scl_s1_q <= 1'b1;
         scl_s2_q <= 1'b1;
      end else begin
         scl_s1_q <= scl;
         scl_s2_q <= scl_s1_q;
      end
   end

   // Released scl still reads low: a slave is stretching, so freeze the phase.
   assign hold = (phase_q == 2'd2) && !scl_s2_q;
`else
   assign hold = 1'b0;
`endif

   assign tick    = (qcnt_q == (QDIV - 8'd1)) && !hold;
   assign bit_end = tick && (phase_q == 2'd3);
   assign sample  = (phase_q == 2'd3) && (qcnt_q == 8'd0);

   always_comb begin
      state_d    = state_q;
      qcnt_d     = qcnt_q;
      phase_d    = phase_q;
      shift_d    = shift_q;
      bitcnt_d   = bitcnt_q;
      rem_d      = rem_q;
      rw_d       = rw_q;
      busy_d     = busy_q;
      nack_d     = nack_q;
      sended_d   = 1'b0;
      received_d = 1'b0;
      drx_d      = drx_q;

      if (state_q != S_IDLE && !hold) begin
         if (tick) begin
            qcnt_d  = 8'd0;
            phase_d = phase_q + 2'd1;
         end else begin
            qcnt_d = qcnt_q + 8'd1;
         end
      end

      case (state_q)
         S_IDLE: begin
            qcnt_d  = 8'd0;
            phase_d = 2'd0;
            if (start) begin
               state_d  = S_START;
               shift_d  = {address, rw};
               rw_d     = rw;
               rem_d    = len;
               bitcnt_d = 3'd7;
               nack_d   = 1'b0;
               busy_d   = 1'b1;
            end
         end
         S_START: begin
            if (bit_end) state_d = S_ADDR;
         end
         S_ADDR, S_WR: begin
            if (bit_end) begin
               if (bitcnt_q == 3'd0) begin
                  if (state_q == S_ADDR) state_d = S_ADDR_ACK;
                  else                   state_d = S_WR_ACK;
               end else begin
                  bitcnt_d = bitcnt_q - 3'd1;
                  shift_d  = {shift_q[6:0], 1'b0};
               end
            end
         end
         S_ADDR_ACK, S_WR_ACK: begin
            if (sample) begin
               if (sda_s2_q)               nack_d   = 1'b1;
               else if (state_q == S_WR_ACK) sended_d = 1'b1;
            end
            if (bit_end) begin
               if (nack_q || rem_q == 4'd0) begin
                  state_d = S_STOP;
               end else begin
                  rem_d    = rem_q - 4'd1;
                  bitcnt_d = 3'd7;
                  if (rw_q) begin
                     state_d = S_RD;
                  end else begin
                     state_d = S_WR;
                     shift_d = datasend;
                  end
               end
            end
         end
         S_RD: begin
            if (sample) shift_d = {shift_q[6:0], sda_s2_q};
            if (bit_end) begin
               if (bitcnt_q == 3'd0) begin
                  state_d    = S_RD_ACK;
                  drx_d      = shift_q;
                  received_d = 1'b1;
               end else begin
                  bitcnt_d = bitcnt_q - 3'd1;
               end
            end
         end
         S_RD_ACK: begin
            if (bit_end) begin
               if (rem_q == 4'd0) begin
                  state_d = S_STOP;
               end else begin
                  rem_d    = rem_q - 4'd1;
                  bitcnt_d = 3'd7;
                  state_d  = S_RD;
               end
            end
         end
         S_STOP: begin
            if (sample) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_comb begin
      sda_low = 1'b0;
      scl_low = 1'b0;
      case (state_q)
         S_START: sda_low = phase_q[1];
         S_ADDR, S_WR: begin
            scl_low = !phase_q[1];
            sda_low = !shift_q[7];
         end
         S_ADDR_ACK, S_WR_ACK, S_RD: scl_low = !phase_q[1];
         S_RD_ACK: begin
            scl_low = !phase_q[1];
            sda_low = (rem_q != 4'd0);
         end
         S_STOP: begin
            scl_low = !phase_q[1];
            sda_low = (phase_q != 2'd3);
         end
         default: begin
            sda_low = 1'b0;
            scl_low = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         qcnt_q     <= 8'd0;
         phase_q    <= 2'd0;
         shift_q    <= 8'd0;
         bitcnt_q   <= 3'd0;
         rem_q      <= 4'd0;
         rw_q       <= 1'b0;
         busy_q     <= 1'b0;
         nack_q     <= 1'b0;
         sended_q   <= 1'b0;
         received_q <= 1'b0;
         drx_q      <= 8'h00;
         sda_s1_q   <= 1'b1;
         sda_s2_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         qcnt_q     <= qcnt_d;
         phase_q    <= phase_d;
         shift_q    <= shift_d;
         bitcnt_q   <= bitcnt_d;
         rem_q      <= rem_d;
         rw_q       <= rw_d;
         busy_q     <= busy_d;
         nack_q     <= nack_d;
         sended_q   <= sended_d;
         received_q <= received_d;
         drx_q      <= drx_d;
         sda_s1_q   <= sda;
         sda_s2_q   <= sda_s1_q;
      end
   end

   assign sda         = sda_low ? 1'b0 : 1'bz;
   assign scl         = scl_low ? 1'b0 : 1'bz;
   assign sended      = sended_q;
   assign received    = received_q;
   assign datareceive = drx_q;
   assign busy        = busy_q;
   assign nack        = nack_q;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master: vector table of transactions against a behavioural slave/bus logger.
module tb_i2c_master;
   localparam logic [7:0] QDIV = 8'd4;
`ifdef I2C_MASTER_STRETCH_EN
   localparam int BITP = 4 * QDIV + 2;
`else
   localparam int BITP = 4 * QDIV;
`endif
   localparam int NV = 6;
   localparam int STRETCH = 40;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, start, rw;
   logic [6:0] address;
   logic [3:0] len;
   logic [7:0] datasend;
   logic       sended, received, busy, nack;
   logic [7:0] datareceive;
   wire        sda_w, scl_w;

   pullup (sda_w);
   pullup (scl_w);

   logic slv_sda_low = 1'b0;
   logic slv_scl_low = 1'b0;
   assign sda_w = slv_sda_low ? 1'b0 : 1'bz;
   assign scl_w = slv_scl_low ? 1'b0 : 1'bz;

   i2c_master #(.QDIV(QDIV)) dut (
      .clk(clk), .reset(reset), .sda(sda_w), .scl(scl_w),
      .start(start), .address(address), .rw(rw), .len(len),
      .datasend(datasend), .sended(sended), .datareceive(datareceive),
      .received(received), .busy(busy), .nack(nack)
   );

   typedef struct packed {
      logic [6:0]      addr;
      logic            rw;
      logic [3:0]      len;
      logic            present;
      logic [3:0][7:0] d;
      logic            exp_nack;
      logic [3:0]      exp_sended;
      logic [3:0]      exp_received;
   } vec_t;

   vec_t vecs[NV];
   int   durs[NV];
   int   checks = 0;
   int   errors = 0;

   // slave configuration (written by the test only)
   logic [6:0] slv_addr = 7'h00;
   logic       slv_present = 1'b0;
   logic [7:0] rd_data[4];
   logic       stretch_on = 1'b0;

   // slave / bus logger state (written by the monitor only)
   logic        act = 1'b0, sel = 1'b0, rdm = 1'b0, is_addr = 1'b0, ackbit = 1'b0;
   logic        scl_p = 1'b1, sda_p = 1'b1;
   logic [7:0]  sh = 8'h00, rbyte = 8'h00;
   int          bitn = 0, ridx = 0, stretch_cnt = 0, log_n = 0;
   logic [11:0] evlog[256];

   task automatic push(input logic [11:0] e);
      if (log_n < 256) evlog[log_n] = e;
      log_n++;
   endtask

   always @(negedge clk) begin
      if (stretch_cnt > 0) begin
         stretch_cnt--;
         if (stretch_cnt == 0) slv_scl_low = 1'b0;
      end
      if (scl_w && scl_p && sda_p && !sda_w) begin
         act = 1'b1; bitn = 0; is_addr = 1'b1; sel = 1'b0; ridx = 0; slv_sda_low = 1'b0;
         push({4'h1, 8'h00});
      end else if (scl_w && scl_p && !sda_p && sda_w) begin
         act = 1'b0; slv_sda_low = 1'b0;
         push({4'h2, 8'h00});
      end else if (act && !scl_p && scl_w) begin
         if (bitn < 8) sh = {sh[6:0], sda_w};
         else          ackbit = sda_w;
         bitn++;
      end else if (act && scl_p && !scl_w) begin
         if (bitn == 8) begin
            push({4'h3, sh});
            if (is_addr) begin
               sel = slv_present && (sh[7:1] == slv_addr);
               rdm = sh[0];
               slv_sda_low = sel;
            end else begin
               slv_sda_low = sel && !rdm;
               if (sel && !rdm && stretch_on) begin
                  slv_scl_low = 1'b1;
                  stretch_cnt = STRETCH;
               end
            end
         end else if (bitn == 9) begin
            push({4'h4, 7'h00, ackbit});
            bitn = 0;
            if (sel && rdm && (is_addr || !ackbit) && ridx < 4) begin
               rbyte = rd_data[ridx];
               ridx++;
               slv_sda_low = !rbyte[7];
            end else begin
               slv_sda_low = 1'b0;
            end
            is_addr = 1'b0;
         end else if (sel && rdm && !is_addr && bitn >= 1 && bitn <= 7) begin
            slv_sda_low = !rbyte[7 - bitn];
         end
      end
      scl_p = scl_w;
      sda_p = sda_w;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   function automatic vec_t mk(input logic [6:0] a, input logic r, input logic [3:0] l,
                               input logic p, input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input logic en, input logic [3:0] es,
                               input logic [3:0] er);
      vec_t v;
      v.addr = a; v.rw = r; v.len = l; v.present = p;
      v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = 8'h00;
      v.exp_nack = en; v.exp_sended = es; v.exp_received = er;
      return v;
   endfunction

   task automatic run_txn(input int vi, output int dur);
      vec_t        v;
      int          base, widx, scnt, rcnt, cyc;
      logic [11:0] exp_ev[$];
      logic        ackexp;
      v = vecs[vi];
      slv_present = v.present;
      slv_addr    = v.addr;
      for (int i = 0; i < 4; i++) rd_data[i] = v.d[i];
      base = log_n;
      @(posedge clk); #1;
      chk($sformatf("v%0d_busy_idle", vi), 32'(busy), 32'd0);
      address = v.addr; rw = v.rw; len = v.len; datasend = v.d[0]; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk($sformatf("v%0d_busy_rise", vi), 32'(busy), 32'd1);
      dur = 1; widx = 0; scnt = 0; rcnt = 0; cyc = 0;
      while (busy && cyc < 20000) begin
         @(posedge clk); #1;
         cyc++;
         if (sended) begin
            scnt++;
            widx++;
            datasend = (widx < 4) ? v.d[widx] : 8'h00;
         end
         if (received) begin
            chk($sformatf("v%0d_rx%0d", vi, rcnt), 32'(datareceive),
                (rcnt < 4) ? 32'(v.d[rcnt]) : 32'hFFFF_FFFF);
            rcnt++;
         end
         if (busy) dur++;
      end
      chk($sformatf("v%0d_timeout_busy", vi), 32'(busy), 32'd0);
      chk($sformatf("v%0d_nack", vi), 32'(nack), 32'(v.exp_nack));
      chk($sformatf("v%0d_sended_cnt", vi), 32'(scnt), 32'(v.exp_sended));
      chk($sformatf("v%0d_received_cnt", vi), 32'(rcnt), 32'(v.exp_received));

      exp_ev.push_back({4'h1, 8'h00});
      exp_ev.push_back({4'h3, v.addr, v.rw});
      exp_ev.push_back({4'h4, 7'h00, !v.present});
      if (v.present) begin
         for (int i = 0; i < int'(v.len); i++) begin
            ackexp = v.rw && (i == int'(v.len) - 1);
            exp_ev.push_back({4'h3, v.d[i]});
            exp_ev.push_back({4'h4, 7'h00, ackexp});
         end
      end
      exp_ev.push_back({4'h2, 8'h00});
      chk($sformatf("v%0d_bus_event_cnt", vi), 32'(log_n - base), 32'(exp_ev.size()));
      for (int i = 0; i < exp_ev.size(); i++) begin
         if (base + i < 256 && base + i < log_n)
            chk($sformatf("v%0d_bus_ev%0d", vi, i), 32'(evlog[base + i]), 32'(exp_ev[i]));
      end
   endtask

   initial begin
      int d_ref, d_str, d_after;
      reset = 1'b1; start = 1'b0; address = 7'h00; rw = 1'b0; len = 4'd0; datasend = 8'h00;
      for (int i = 0; i < 4; i++) rd_data[i] = 8'h00;

      vecs[0] = mk(7'h3A, 1'b0, 4'd2, 1'b1, 8'hA5, 8'h3C, 8'h00, 1'b0, 4'd2, 4'd0);
      vecs[1] = mk(7'h50, 1'b1, 4'd3, 1'b1, 8'h11, 8'h22, 8'h33, 1'b0, 4'd0, 4'd3);
      vecs[2] = mk(7'h12, 1'b0, 4'd4, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 4'd0, 4'd0);
      vecs[3] = mk(7'h3A, 1'b0, 4'd0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 4'd0, 4'd0);
      vecs[4] = mk(7'h7F, 1'b1, 4'd1, 1'b1, 8'hC3, 8'h00, 8'h00, 1'b0, 4'd0, 4'd1);
      vecs[5] = mk(7'h3A, 1'b0, 4'd1, 1'b1, 8'h96, 8'h00, 8'h00, 1'b0, 4'd1, 4'd0);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_nack", 32'(nack), 32'd0);
      chk("rst_sended", 32'(sended), 32'd0);
      chk("rst_received", 32'(received), 32'd0);
      chk("rst_datareceive", 32'(datareceive), 32'h00);
      chk("rst_sda", 32'(sda_w), 32'd1);
      chk("rst_scl", 32'(scl_w), 32'd1);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) run_txn(i, durs[i]);

      checks++;
      if (durs[3] < 9 * BITP || durs[3] > 11 * BITP) begin
         errors++;
         $display("FAIL probe_busy_duration: got %0d clk expected %0d..%0d", durs[3], 9 * BITP, 11 * BITP);
      end

      // reset during bit 4 of address 0x22 (write): that bit is 0, scl low in phase 1
      slv_present = 1'b1; slv_addr = 7'h3A;
      @(posedge clk); #1;
      address = 7'h22; rw = 1'b0; len = 4'd1; datasend = 8'h55; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (16 + 3 * 16 + 6) @(posedge clk);
      #1;
      chk("mid_scl_low", 32'(scl_w), 32'd0);
      chk("mid_sda_low", 32'(sda_w), 32'd0);
      chk("mid_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_scl", 32'(scl_w), 32'd1);
      chk("mid_rst_sda", 32'(sda_w), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_nack", 32'(nack), 32'd0);
      reset = 1'b0;
      repeat (4) @(posedge clk);
      run_txn(0, d_after);

`ifdef I2C_MASTER_STRETCH_EN
      run_txn(5, d_ref);
      stretch_on = 1'b1;
      run_txn(5, d_str);
      stretch_on = 1'b0;
      checks++;
      if (d_str - d_ref < STRETCH - 2 * int'(QDIV) - 2 || d_str - d_ref > STRETCH - 2 * int'(QDIV) + 2) begin
         errors++;
         $display("FAIL stretch_delay: got %0d clk extra expected about %0d", d_str - d_ref,
                  STRETCH - 2 * int'(QDIV));
      end
`else
      d_ref = 0;
      d_str = 0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
